// File: rtl/swu_ctrl_pkg.sv
// Shared configuration and elaboration helpers for the sliding-window
// buffer controller.
package swu_ctrl_pkg;

    // Default geometry of the sliding-window unit
    localparam int DEF_SIMD          = 1;
    localparam int DEF_IFM_CHANNELS  = 2;
    localparam int DEF_IFM_WIDTH     = 6;
    localparam int DEF_IFM_HEIGHT    = 6;
    localparam int DEF_KERNEL_WIDTH  = 3;
    localparam int DEF_KERNEL_HEIGHT = 3;
    localparam int DEF_STRIDE        = 2;
    localparam int DEF_OFM_WIDTH     = 2;
    localparam int DEF_OFM_HEIGHT    = 2;
    localparam int DEF_BUFFER_SIZE   = 36;

    // Derived frame totals for the default geometry
    localparam int CF        = DEF_IFM_CHANNELS / DEF_SIMD;
    localparam int ROW_WORDS = DEF_IFM_WIDTH * CF;
    localparam int WTOT      = DEF_IFM_HEIGHT * ROW_WORDS;
    localparam int RTOT      = DEF_OFM_HEIGHT * DEF_OFM_WIDTH *
                               DEF_KERNEL_HEIGHT * DEF_KERNEL_WIDTH * CF;

    // Smallest buffer that holds KERNEL_HEIGHT-1 full rows plus the span of one window row band
    function automatic int min_buffer_size(input int kh, input int kw, input int ifm_w,
                                           input int ofm_w, input int stride, input int cf);
        return (kh - 1) * ifm_w * cf + ((ofm_w - 1) * stride + kw) * cf;
    endfunction

    function automatic bit buffer_size_ok(input int bsize, input int kh, input int kw,
                                          input int ifm_w, input int ofm_w, input int stride,
                                          input int cf);
        return bsize >= min_buffer_size(kh, kw, ifm_w, ofm_w, stride, cf);
    endfunction

    // Counter width able to hold values 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int  MIN_BUFFER_SIZE = min_buffer_size(DEF_KERNEL_HEIGHT, DEF_KERNEL_WIDTH,
                                                      DEF_IFM_WIDTH, DEF_OFM_WIDTH,
                                                      DEF_STRIDE, CF);
    localparam bit  DEF_BUFFER_OK   = DEF_BUFFER_SIZE >= MIN_BUFFER_SIZE;

endpackage

// File: rtl/swu_rd_seq.sv
// Read-side window walker: nested c/kx/ky/ox/oy counters, the linear word
// index of the current element and its wrapped buffer address.
module swu_rd_seq
    import swu_ctrl_pkg::*;
#(
    parameter int CF_N        = 2,
    parameter int IFM_W       = 6,
    parameter int KW          = 3,
    parameter int KH          = 3,
    parameter int STRIDE      = 2,
    parameter int OW          = 2,
    parameter int OH          = 2,
    parameter int BUFFER_SIZE = 36,
    parameter int AW          = 6,
    parameter int CW          = 7
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] idx,
    output logic [AW-1:0] rd_addr,
    output logic          rd_last,
    output logic          rd_frame_last,
    output logic          oy_step
);
    localparam int CFW = cnt_width(CF_N);
    localparam int KXW = cnt_width(KW);
    localparam int KYW = cnt_width(KH);
    localparam int OXW = cnt_width(OW);
    localparam int OYW = cnt_width(OH);

    // Address steps reduced modulo the buffer depth so one conditional subtract wraps them
    localparam logic [AW-1:0] ELEM_STEP = AW'(1 % BUFFER_SIZE);
    localparam logic [AW-1:0] ROW_STEP  = AW'((IFM_W * CF_N) % BUFFER_SIZE);
    localparam logic [AW-1:0] WIN_STEP  = AW'((STRIDE * CF_N) % BUFFER_SIZE);
    localparam logic [AW-1:0] LINE_STEP = AW'((STRIDE * IFM_W * CF_N) % BUFFER_SIZE);

    localparam logic [CW-1:0] S_C  = CW'(STRIDE);
    localparam logic [CW-1:0] W_C  = CW'(IFM_W);
    localparam logic [CW-1:0] CF_C = CW'(CF_N);

    logic [CFW-1:0] c_q, c_d;
    logic [KXW-1:0] kx_q, kx_d;
    logic [KYW-1:0] ky_q, ky_d;
    logic [OXW-1:0] ox_q, ox_d;
    logic [OYW-1:0] oy_q, oy_d;
    // Base addresses of the current output row, window and window row
    logic [AW-1:0]  line_q, line_d, win_q, win_d, row_q, row_d, addr_q, addr_d;
    logic           c_last, kx_last, ky_last, ox_last, oy_last;

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] step);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, step};
        if (s >= (AW+1)'(BUFFER_SIZE)) s = s - (AW+1)'(BUFFER_SIZE);
        return s[AW-1:0];
    endfunction

    // Terminal-count flags, window-end flags and the element's linear index
    always_comb begin
        c_last        = (c_q  == CFW'(CF_N - 1));
        kx_last       = (kx_q == KXW'(KW - 1));
        ky_last       = (ky_q == KYW'(KH - 1));
        ox_last       = (ox_q == OXW'(OW - 1));
        oy_last       = (oy_q == OYW'(OH - 1));
        rd_last       = ky_last && kx_last && c_last;
        rd_frame_last = rd_last && ox_last && oy_last;
        oy_step       = adv && rd_last && ox_last;
        idx           = ((CW'(oy_q) * S_C + CW'(ky_q)) * W_C + CW'(ox_q) * S_C + CW'(kx_q)) * CF_C
                        + CW'(c_q);
        rd_addr       = addr_q;
    end

    // Advance the walk one element, c innermost, oy outermost; wraps to frame start after the last element
    always_comb begin
        c_d    = c_q;
        kx_d   = kx_q;
        ky_d   = ky_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        line_d = line_q;
        win_d  = win_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (adv) begin
            if (!c_last) begin
                c_d    = c_q + CFW'(1);
                addr_d = wrap_add(addr_q, ELEM_STEP);
            end else if (!kx_last) begin
                c_d    = '0;
                kx_d   = kx_q + KXW'(1);
                addr_d = wrap_add(addr_q, ELEM_STEP);
            end else if (!ky_last) begin
                c_d    = '0;
                kx_d   = '0;
                ky_d   = ky_q + KYW'(1);
                row_d  = wrap_add(row_q, ROW_STEP);
                addr_d = wrap_add(row_q, ROW_STEP);
            end else if (!ox_last) begin
                c_d    = '0;
                kx_d   = '0;
                ky_d   = '0;
                ox_d   = ox_q + OXW'(1);
                win_d  = wrap_add(win_q, WIN_STEP);
                row_d  = wrap_add(win_q, WIN_STEP);
                addr_d = wrap_add(win_q, WIN_STEP);
            end else begin
                c_d  = '0;
                kx_d = '0;
                ky_d = '0;
                ox_d = '0;
                if (!oy_last) begin
                    oy_d   = oy_q + OYW'(1);
                    line_d = wrap_add(line_q, LINE_STEP);
                    win_d  = wrap_add(line_q, LINE_STEP);
                    row_d  = wrap_add(line_q, LINE_STEP);
                    addr_d = wrap_add(line_q, LINE_STEP);
                end else begin
                    oy_d   = '0;
                    line_d = '0;
                    win_d  = '0;
                    row_d  = '0;
                    addr_d = '0;
                end
            end
        end
    end

    // Counter and address registers; clr covers both reset and frame restart
    always_ff @(posedge clk) begin
        if (clr) begin
            c_q    <= '0;
            kx_q   <= '0;
            ky_q   <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            line_q <= '0;
            win_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            c_q    <= c_d;
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            line_q <= line_d;
            win_q  <= win_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/swu_buffer_ctrl.sv
// Address and flow controller for the sliding-window circular line buffer:
// write gating against unread words, read residency check and frame restart.
module swu_buffer_ctrl
    import swu_ctrl_pkg::*;
#(
    parameter int SIMD          = DEF_SIMD,
    parameter int IFMChannels   = DEF_IFM_CHANNELS,
    parameter int IFMWidth      = DEF_IFM_WIDTH,
    parameter int IFMHeight     = DEF_IFM_HEIGHT,
    parameter int KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
    parameter int KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
    parameter int STRIDE        = DEF_STRIDE,
    parameter int OFMWidth      = DEF_OFM_WIDTH,
    parameter int OFMHeight     = DEF_OFM_HEIGHT,
    parameter int BUFFER_SIZE   = DEF_BUFFER_SIZE,
    parameter int AW            = $clog2(BUFFER_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ip_axis_tvalid,
    output logic          ip_axis_tready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr,
    output logic          rd_last,
    output logic          rd_frame_last,
    output logic          frame_done
);
    localparam int NCF        = IFMChannels / SIMD;
    localparam int LINE_WORDS = STRIDE * IFMWidth * NCF;
    localparam int WTOT_N     = IFMHeight * IFMWidth * NCF;
    // Wide enough for wr_cnt and for free_base after its final step past the last output row
    localparam int CW         = cnt_width(WTOT_N + LINE_WORDS + 1);

    localparam logic [CW-1:0] WTOT_C = CW'(WTOT_N);
    localparam logic [CW-1:0] LINE_C = CW'(LINE_WORDS);
    localparam logic [CW-1:0] BUF_C  = CW'(BUFFER_SIZE);

    if (!buffer_size_ok(BUFFER_SIZE, KERNEL_HEIGHT, KERNEL_WIDTH, IFMWidth,
                        OFMWidth, STRIDE, NCF)) begin : g_buffer_too_small
        $error("swu_buffer_ctrl: BUFFER_SIZE below minimum for this geometry");
    end

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] free_base_q, free_base_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          rd_done_q, rd_done_d;
    logic [CW-1:0] rd_idx;
    logic          rd_adv, oy_step, frame_end, space_ok;

    swu_rd_seq #(
        .CF_N        (NCF),
        .IFM_W       (IFMWidth),
        .KW          (KERNEL_WIDTH),
        .KH          (KERNEL_HEIGHT),
        .STRIDE      (STRIDE),
        .OW          (OFMWidth),
        .OH          (OFMHeight),
        .BUFFER_SIZE (BUFFER_SIZE),
        .AW          (AW),
        .CW          (CW)
    ) u_rd_seq (
        .clk           (clk),
        .clr           (reset || frame_end),
        .adv           (rd_adv),
        .idx           (rd_idx),
        .rd_addr       (rd_addr),
        .rd_last       (rd_last),
        .rd_frame_last (rd_frame_last),
        .oy_step       (oy_step)
    );

    // Handshake decode: a write may not run more than BUFFER_SIZE words ahead of the oldest needed word
    always_comb begin
        space_ok       = (wr_cnt_q < free_base_q) || ((wr_cnt_q - free_base_q) < BUF_C);
        ip_axis_tready = !reset && (wr_cnt_q < WTOT_C) && space_ok;
        wr_en          = ip_axis_tvalid && ip_axis_tready;
        wr_addr        = wr_ptr_q;
        rd_valid       = !reset && !rd_done_q && (rd_idx < wr_cnt_q);
        rd_adv         = rd_valid && rd_ready;
        frame_end      = rd_done_q && (wr_cnt_q == WTOT_C);
        frame_done     = !reset && frame_end;
    end

    // Write count/pointer, freed-space base and read completion; all clear together at frame end
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        free_base_d = free_base_q;
        rd_done_d   = rd_done_q;
        if (frame_end) begin
            wr_cnt_d    = '0;
            wr_ptr_d    = '0;
            free_base_d = '0;
            rd_done_d   = 1'b0;
        end else begin
            if (wr_en) begin
                wr_cnt_d = wr_cnt_q + CW'(1);
                wr_ptr_d = (wr_ptr_q == AW'(BUFFER_SIZE - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
            if (oy_step) begin
                free_base_d = free_base_q + LINE_C;
            end
            if (rd_adv && rd_frame_last) begin
                rd_done_d = 1'b1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            free_base_q <= '0;
            rd_done_q   <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            free_base_q <= free_base_d;
            rd_done_q   <= rd_done_d;
        end
    end

endmodule

// File: doc/swu_buffer_ctrl.md
Name: swu_buffer_ctrl

Overview:
- Address and flow controller for the sliding-window unit's circular line buffer (BUFFER_SIZE words, one word = SIMD channels).
- Write side: gates the input stream and issues buffer write addresses.
- Read side: walks every output window (oy, ox, ky, kx, channel-fold) and issues read addresses only when the word is resident. Writes are accepted only when they cannot overwrite a word still needed.
- Sits between the input AXI-Stream and the buffer RAM. The datapath (RAM, output packing) is outside this block.

Parameters:
- SIMD, 1, channels per buffer word
- IFMChannels, 2, input channels; must be a multiple of SIMD; CF = IFMChannels/SIMD
- IFMWidth, 6, input width in pixels
- IFMHeight, 6, input height in pixels
- KERNEL_WIDTH, 3, window width
- KERNEL_HEIGHT, 3, window height
- STRIDE, 2, window stride (both axes)
- OFMWidth, 2, output width; equals (IFMWidth-KERNEL_WIDTH)/STRIDE+1
- OFMHeight, 2, output height; same formula on the vertical axis
- BUFFER_SIZE, 36, buffer depth in words; must be >= (KERNEL_HEIGHT-1)*IFMWidth*CF + ((OFMWidth-1)*STRIDE+KERNEL_WIDTH)*CF
- AW, $clog2(BUFFER_SIZE), address width

Ports:
- clk, in, 1, the single clock
- reset, in, 1, synchronous, active-high
- ip_axis_tvalid, in, 1, input word valid
- ip_axis_tready, out, 1, input word accepted this cycle when tvalid is also high
- wr_en, out, 1, buffer write strobe; equals ip_axis_tvalid & ip_axis_tready
- wr_addr, out, AW, buffer write address
- rd_valid, out, 1, rd_addr is valid
- rd_ready, in, 1, consumer takes rd_addr
- rd_addr, out, AW, buffer read address
- rd_last, out, 1, last element of the current window
- rd_frame_last, out, 1, last element of the frame
- frame_done, out, 1, one-cycle pulse when the controller returns to frame start

Behaviour:
- Index and totals:
  - Linear word index idx = (row*IFMWidth + col)*CF + c.
  - Buffer address = idx mod BUFFER_SIZE. Generate it with wrapping counters; no divider.
  - Per frame: WTOT = IFMHeight*IFMWidth*CF writes; RTOT = OFMHeight*OFMWidth*KERNEL_HEIGHT*KERNEL_WIDTH*CF reads.
- Registered state: wr_cnt (0..WTOT), wr_ptr, read counters (oy, ox, ky, kx, c), free_base = oy*STRIDE*IFMWidth*CF, rd_done flag.
- Write side:
  - ip_axis_tready = !reset && wr_cnt < WTOT && (wr_cnt - free_base) < BUFFER_SIZE.
  - On wr_en: wr_cnt++, and wr_ptr wraps at BUFFER_SIZE.
  - wr_addr = wr_ptr.
- Read side:
  - Current idx = ((oy*STRIDE+ky)*IFMWidth + ox*STRIDE+kx)*CF + c.
  - rd_valid = !rd_done && idx < wr_cnt, using the registered wr_cnt. A written word is therefore readable at the earliest one cycle after its wr_en.
  - Iteration order, innermost first: c, kx, ky, ox, oy.
  - The read state advances only on rd_valid & rd_ready. rd_addr, rd_last and rd_frame_last stay stable while rd_valid & !rd_ready.
  - rd_last = (ky==KERNEL_HEIGHT-1 && kx==KERNEL_WIDTH-1 && c==CF-1).
  - rd_frame_last = rd_last && ox==OFMWidth-1 && oy==OFMHeight-1.
  - When oy increments, free_base increases by STRIDE*IFMWidth*CF in the same cycle.
  - Accepting the rd_frame_last element sets rd_done.
- Frame end:
  - When rd_done && wr_cnt==WTOT: all counters, pointers, free_base and rd_done clear to 0 in the next cycle, and frame_done pulses for that one cycle.
  - Trailing input rows that no window uses (for example row 5 at the defaults) are still written.
  - ip_axis_tready is 0 while wr_cnt==WTOT.
- Simultaneous events: a write and a read in the same cycle are both legal. Space freed by an oy increment becomes usable in the following cycle.
- Reset, including mid-frame:
  - All state returns to 0.
  - ip_axis_tready=0, rd_valid=0, rd_last=0, rd_frame_last=0, frame_done=0, wr_addr=0, rd_addr=0.
  - Partial frame data is discarded.

Decomposition:
- Package swu_ctrl_pkg holds:
  - CF, WTOT, RTOT, the row stride word count (IFMWidth*CF);
  - a function computing the minimum legal BUFFER_SIZE;
  - an elaboration-time check that BUFFER_SIZE is not below that minimum.
- One sub-module, swu_rd_seq: nested c/kx/ky/ox/oy counters, idx and wrapping rd_addr generation, last flags.
- The top level holds write gating, free_base, and the frame-end logic.

Test Plan:
- Defaults, rd_ready=0, tvalid=1 from reset release -> exactly 36 wr_en, wr_addr 0..35, then tready=0. rd_valid first rises the cycle after the first write with rd_addr=0.
- Defaults, rd_ready=1 -> window (0,0) rd_addr sequence 0,1,2,3,4,5,12,13,14,15,16,17,24,25,26,27,28,29 with rd_last on the 18th. Window (0,1) starts at rd_addr 4.
- Stall then release: after 36 reads, oy→1 and free_base=24. Writes resume and write 36 lands at wr_addr 0. Window (1,0) begins at idx 24 (addr 24), and idx 36 reads from addr 0.
- Full frame, both sides free-running -> 72 writes, 72 reads, rd_frame_last on read 72 (idx 57, addr 21), then frame_done pulse. The next frame's first write is at wr_addr 0.
- rd_ready toggled every cycle, tvalid random -> rd_addr/rd_last are held stable during stalls. No read of idx >= wr_cnt, and wr_cnt - free_base never exceeds 36.
- reset asserted mid-frame (after 20 writes, 10 reads) -> next cycle all outputs 0. The following frame replays the first-scenario addresses exactly.
